// File: rtl/sys_row_pkg.sv
// Shared types and helpers for the output-stationary systolic row.
// Holds the job FSM state, width-derivation functions and the signed-add overflow check.
package sys_row_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_FLUSH,
        ST_DRAIN
    } state_t;

    // Width of k_len: must represent K_MAX itself.
    function automatic int calc_kw(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int calc_sw(input int s);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    // Two's-complement add overflows when both operands share a sign the result lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/sys_pe_mac.sv
// One output-stationary MAC PE: registered a/valid/b pass-through and a wrapping accumulator.
// Sticky overflow flag and accumulator are both cleared by i_clr.
module sys_pe_mac
    import sys_row_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic [N-1:0] i_a,
    input  logic         i_a_vld,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_a,
    output logic         o_a_vld,
    output logic [N-1:0] o_b,
    output logic [M-1:0] o_acc,
    output logic         o_ovf
);

    logic signed [2*N-1:0] w_prod;
    logic signed [M-1:0]   w_prod_ext;
    logic signed [M-1:0]   w_sum;
    logic signed [M-1:0]   r_acc;
    logic [N-1:0]          r_a;
    logic                  r_a_vld;
    logic [N-1:0]          r_b;
    logic                  r_ovf;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    assign w_prod_ext = M'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;

    // NOTE: all state uses non-blocking assignment so the next PE sees this PE's previous-cycle value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_a_vld <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_a     <= i_a;
            r_a_vld <= i_a_vld;
            r_b     <= i_b;
            if (i_clr) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (i_a_vld) begin
                r_acc <= w_sum;
                if (add_ovf(r_acc[M-1], w_prod_ext[M-1], w_sum[M-1])) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign o_a     = r_a;
    assign o_a_vld = r_a_vld;
    assign o_b     = r_b;
    assign o_acc   = r_acc;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/sys_row_os.sv
// Output-stationary systolic row of S MAC PEs with job FSM, valid/ready drain and sticky overflow.
// Define SYS_ROW_SKEW_EN to skew the b lanes internally so callers present a and b unskewed.
module sys_row_os
    import sys_row_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 18,
    parameter int S     = 8,
    parameter int K_MAX = 256,
    parameter int KW    = calc_kw(K_MAX),
    parameter int SW    = calc_sw(S)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [KW-1:0]  k_len,
    input  logic [N-1:0]   a_in,
    input  logic [S*N-1:0] b_in,
    input  logic           a_valid,
    output logic           a_ready,
    output logic [N-1:0]   a_out,
    output logic [S*N-1:0] b_out,
    output logic [M-1:0]   d_data,
    output logic [SW-1:0]  d_idx,
    output logic           d_valid,
    input  logic           d_ready,
    output logic           d_last,
    output logic           ovf,
    output logic           busy,
    output logic           done
);

    state_t        r_state;
    logic [KW-1:0] r_k_len;
    logic [KW-1:0] r_beat_cnt;
    logic [SW-1:0] r_flush_cnt;
    logic [SW-1:0] r_idx;
    logic          r_a_ready;
    logic          r_d_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_start_ok;
    logic          w_clr;
    logic          w_beat;
    logic [N-1:0]  w_a   [S+1];
    logic [S:0]    w_vld;
    logic [N-1:0]  w_b_lane [S];
    logic [M-1:0]  w_acc [S];
    logic [S-1:0]  w_ovf;

    assign w_start_ok = start && (k_len != '0) && (k_len <= KW'(K_MAX));
    assign w_clr      = (r_state == ST_IDLE) && w_start_ok;
    assign w_beat     = a_valid && r_a_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_idx       <= '0;
            r_a_ready   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_k_len    <= k_len;
                        r_beat_cnt <= '0;
                        r_idx      <= '0;
                        r_a_ready  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + KW'(1);
                        if (r_beat_cnt + KW'(1) == r_k_len) begin
                            r_a_ready   <= 1'b0;
                            r_flush_cnt <= '0;
                            r_state     <= ST_FLUSH;
                        end
                    end
                end
                // The last beat needs S-1 more cycles to reach PE S-1.
                ST_FLUSH: begin
                    if (r_flush_cnt == SW'(S-2)) begin
                        r_d_valid <= 1'b1;
                        r_idx     <= '0;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + SW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (d_ready) begin
                        if (r_idx == SW'(S-1)) begin
                            r_d_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + SW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYS_ROW_SKEW_EN
    // Lane g is delayed g cycles so it meets its a beat at PE g.
    for (genvar g = 0; g < S; g++) begin : g_skew
        if (g == 0) begin : g_direct
            assign w_b_lane[0] = b_in[0 +: N];
        end else begin : g_dl
            logic [N-1:0] r_dl [g];
            // NOTE: this small delay array is reset explicitly; it is flops, not a RAM.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < g; j++) r_dl[j] <= '0;
                end else if (w_clr) begin
                    for (int j = 0; j < g; j++) r_dl[j] <= '0;
                end else begin
                    r_dl[0] <= b_in[g*N +: N];
                    for (int j = 1; j < g; j++) r_dl[j] <= r_dl[j-1];
                end
            end
            assign w_b_lane[g] = r_dl[g-1];
        end
    end
`else
    for (genvar g = 0; g < S; g++) begin : g_lane
        assign w_b_lane[g] = b_in[g*N +: N];
    end
`endif

    assign w_a[0]   = a_in;
    assign w_vld[0] = w_beat;

    for (genvar g = 0; g < S; g++) begin : g_pe
        sys_pe_mac #(
            .N (N),
            .M (M)
        ) u_pe (
            .clk     (clk),
            .rst     (rst),
            .i_clr   (w_clr),
            .i_a     (w_a[g]),
            .i_a_vld (w_vld[g]),
            .i_b     (w_b_lane[g]),
            .o_a     (w_a[g+1]),
            .o_a_vld (w_vld[g+1]),
            .o_b     (b_out[g*N +: N]),
            .o_acc   (w_acc[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    assign a_out   = w_a[S];
    assign a_ready = r_a_ready;
    assign d_valid = r_d_valid;
    assign d_idx   = r_idx;
    assign d_data  = r_d_valid ? w_acc[r_idx] : '0;
    assign d_last  = r_d_valid && (r_idx == SW'(S-1));
    assign ovf     = |w_ovf;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sys_row_os.sv
// Scoreboard bench for sys_row_os (S=4, N=8, M=18); skews b itself unless SYS_ROW_SKEW_EN is defined.
// A reference model pushes expected drain beats; a monitor pops and compares on each transfer.
module tb_sys_row_os;

    localparam int S = 4;
    localparam int N = 8;
    localparam int M = 18;

    logic           clk;
    logic           rst;
    logic           start;
    logic [8:0]     k_len;
    logic [N-1:0]   a_in;
    logic [S*N-1:0] b_in;
    logic [S*N-1:0] b_raw;
    logic           a_valid;
    logic           a_ready;
    logic [N-1:0]   a_out;
    logic [S*N-1:0] b_out;
    logic [M-1:0]   d_data;
    logic [1:0]     d_idx;
    logic           d_valid;
    logic           d_ready;
    logic           d_last;
    logic           ovf;
    logic           busy;
    logic           done;

    typedef struct {
        logic [M-1:0] data;
        logic [1:0]   idx;
    } exp_t;

    exp_t       sb[$];
    longint     m_acc [S];
    bit         m_ovf;
    int         n_checks;
    int         n_errors;
    bit         done_pending;
    logic [S*N-1:0] b_hist [S-1];

    sys_row_os #(.N(N), .M(M), .S(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .k_len   (k_len),
        .a_in    (a_in),
        .b_in    (b_in),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_out   (a_out),
        .b_out   (b_out),
        .d_data  (d_data),
        .d_idx   (d_idx),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_last  (d_last),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller-side skew: lane i carries the raw b from i cycles ago.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S-1; i++) b_hist[i] <= '0;
        end else begin
            b_hist[0] <= b_raw;
            for (int i = 1; i < S-1; i++) b_hist[i] <= b_hist[i-1];
        end
    end

    always_comb begin
        b_in = b_raw;
`ifndef SYS_ROW_SKEW_EN
        for (int i = 1; i < S; i++) b_in[i*N +: N] = b_hist[i-1][i*N +: N];
`endif
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int l = 0; l < S; l++) m_acc[l] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_beat(input logic [N-1:0] a, input logic [S*N-1:0] bl);
        longint p;
        longint s;
        for (int l = 0; l < S; l++) begin
            p = longint'($signed(a)) * longint'($signed(bl[l*N +: N]));
            s = m_acc[l] + p;
            if (s > 131071 || s < -131072) m_ovf = 1'b1;
            s = s & 64'h3FFFF;
            if (s >= 131072) s = s - 262144;
            m_acc[l] = s;
        end
    endtask

    task automatic model_push();
        for (int l = 0; l < S; l++) sb.push_back('{data: M'(m_acc[l]), idx: 2'(l)});
    endtask

    // Monitor: sampled 1 time unit after the falling edge, away from the active edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (done_pending) begin
            check("done_pulse", done, 1);
            done_pending = 1'b0;
        end else if (done) begin
            check("spurious_done", done, 0);
        end
        if (d_valid && d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_drain", d_valid, 0);
            end else begin
                e = sb.pop_front();
                check("d_data", d_data, e.data);
                check("d_idx", d_idx, e.idx);
                check("d_last", d_last, e.idx == 2'(S-1));
                if (e.idx == 2'(S-1)) done_pending = 1'b1;
            end
        end
    end

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = 9'(k);
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic drive_beat(input logic [N-1:0] a, input logic [S*N-1:0] bl);
        check("a_ready", a_ready, 1);
        a_in    = a;
        a_valid = 1'b1;
        b_raw   = bl;
        model_beat(a, bl);
        @(negedge clk);
        a_in    = '0;
        a_valid = 1'b0;
        b_raw   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // After the final beat: S-1 flush cycles, then DRAIN with the last beat at the row's far end.
    task automatic check_flush(input logic [N-1:0] a_last, input logic [N-1:0] b3_last);
        model_push();
        for (int i = 0; i < S-1; i++) begin
            check("flush_a_ready", a_ready, 0);
            check("flush_d_valid", d_valid, 0);
            @(negedge clk);
        end
        check("drain_d_valid", d_valid, 1);
        check("a_out", a_out, a_last);
        check("b_out3", b_out[(S-1)*N +: N], b3_last);
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 0);
        idle(2);
        check("busy_after_job", busy, 0);
        check("ovf", ovf, m_ovf);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        done_pending = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        k_len   = '0;
        a_in    = '0;
        a_valid = 1'b0;
        b_raw   = '0;
        d_ready = 1'b1;
        model_clear();
        idle(2);
        check("rst_busy", busy, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_d_data", d_data, 0);
        rst = 1'b0;
        idle(2);

        // Basic job: k=1, a=3, b lanes {1,2,3,4}.
        start_job(1);
        drive_beat(8'd3, {8'd4, 8'd3, 8'd2, 8'd1});
        check_flush(8'd3, 8'd4);
        wait_drain();

        // Gaps: two idle cycles between beats.
        start_job(3);
        drive_beat(8'd1, {4{8'd1}});
        idle(2);
        drive_beat(8'd2, {4{8'd1}});
        idle(2);
        drive_beat(8'd3, {4{8'd1}});
        check_flush(8'd3, 8'd1);
        wait_drain();

        // Overflow boundary: 4 x 16384 fits, 8 x 16384 wraps.
        start_job(4);
        for (int i = 0; i < 4; i++) drive_beat(8'h80, {4{8'h80}});
        check_flush(8'h80, 8'h80);
        wait_drain();
        start_job(8);
        for (int i = 0; i < 8; i++) drive_beat(8'h80, {4{8'h80}});
        check_flush(8'h80, 8'h80);
        wait_drain();

        // Backpressure: d_ready low for 5 DRAIN cycles; ovf clears at the accepted start.
        d_ready = 1'b0;
        start_job(2);
        check("ovf_cleared", ovf, 0);
        drive_beat(8'd5, {8'hFE, 8'd2, 8'hFF, 8'd1});
        drive_beat(8'hF9, {8'd6, 8'hFB, 8'd4, 8'd3});
        check_flush(8'hF9, 8'd6);
        for (int i = 0; i < 5; i++) begin
            check("stall_d_valid", d_valid, 1);
            check("stall_d_idx", d_idx, 0);
            check("stall_d_data", d_data, sb[0].data);
            @(negedge clk);
        end
        d_ready = 1'b1;
        wait_drain();

        // start during COMPUTE is ignored.
        start_job(3);
        drive_beat(8'd1, {4{8'd2}});
        start = 1'b1;
        k_len = 9'd1;
        drive_beat(8'd2, {4{8'd2}});
        start = 1'b0;
        check("busy_mid_job", busy, 1);
        drive_beat(8'd3, {4{8'd2}});
        check_flush(8'd3, 8'd2);
        wait_drain();

        // Illegal k_len values are ignored.
        start = 1'b1;
        k_len = 9'd0;
        @(negedge clk);
        start = 1'b0;
        check("k0_busy", busy, 0);
        check("k0_a_ready", a_ready, 0);
        start = 1'b1;
        k_len = 9'd257;
        @(negedge clk);
        start = 1'b0;
        check("k257_busy", busy, 0);

        // Reset mid-DRAIN aborts the job with no done.
        d_ready = 1'b0;
        start_job(1);
        drive_beat(8'd7, {4{8'd1}});
        begin
            int cyc = 0;
            while (!d_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("pre_rst_d_valid", d_valid, 1);
        rst = 1'b1;
        #1;
        sb.delete();
        check("arst_busy", busy, 0);
        check("arst_d_valid", d_valid, 0);
        check("arst_d_data", d_data, 0);
        check("arst_d_last", d_last, 0);
        check("arst_a_out", a_out, 0);
        check("arst_b_out", b_out, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst     = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
